// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU among NUM_REQ requesters.
// Each operation walks IDLE (grant) -> EXEC (ALU enabled one cycle) -> RESP
// (result held until the consumer accepts it).
//
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   req_valid / req_input   - per-requester pending flag and operation payload
//   req_ready               - one-hot, same-cycle accept (IDLE only)
//   alu_enable / alu_input  - drive the shared ALU
//   alu_out                 - registered ALU result
//   resp_valid / resp_ready - response handshake
//   resp_data / resp_id     - result and the index of the requester that owns it
//   busy                    - high whenever the FSM is not idle

package alu_arbiter_pkg;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned IMM_WIDTH   = 12;
  localparam int unsigned INSTR_WIDTH = 4;

  typedef logic [DATA_WIDTH-1:0]  data_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  localparam instr_t INSTR_ADD  = 4'd0;
  localparam instr_t INSTR_SUB  = 4'd1;
  localparam instr_t INSTR_XOR  = 4'd2;
  localparam instr_t INSTR_ADDI = 4'd3;
  localparam instr_t INSTR_BEQ  = 4'd4;

  typedef struct packed {
    data_t                rs1;
    data_t                rs2;
    logic [IMM_WIDTH-1:0] imm12;
    instr_t               instruction;
  } alu_input_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic       [NUM_REQ-1:0]  req_valid,
  input  alu_input_t [NUM_REQ-1:0]  req_input,
  output logic       [NUM_REQ-1:0]  req_ready,
  output logic                      alu_enable,
  output alu_input_t                alu_input,
  input  data_t                     alu_out,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output data_t                     resp_data,
  output logic       [ID_WIDTH-1:0] resp_id,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t              state;
  alu_input_t          op_reg;
  logic [ID_WIDTH-1:0] id_reg;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant;
  logic                grant_found;

  // Round-robin search starting just after the last winner, wrapping at NUM_REQ.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant       = '0;
    cand        = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && req_valid[ID_WIDTH'(cand)]) begin
        grant_found = 1'b1;
        grant       = ID_WIDTH'(cand);
      end
    end
  end

  // Accept is combinational so a requester transfers in the cycle it is granted;
  // reset also masks it because the state is IDLE while reset is held.
  always_comb begin
    req_ready = '0;
    if (!reset && state == S_IDLE && grant_found) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Control FSM with registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= ID_WIDTH'(NUM_REQ - 1);
      op_reg     <= '0;
      id_reg     <= '0;
      alu_enable <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            op_reg     <= req_input[grant];
            id_reg     <= grant;
            rr_ptr     <= grant;
            state      <= S_EXEC;
            alu_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_EXEC: begin
          state      <= S_RESP;
          alu_enable <= 1'b0;
          resp_valid <= 1'b1;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          alu_enable <= 1'b0;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // The ALU holds its result while disabled, so the response is a direct pass-through.
  assign alu_input = op_reg;
  assign resp_data = alu_out;
  assign resp_id   = id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed requests, a behavioural registered ALU,
// and a scoreboard queue checked by an independent response monitor.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0] id;
    data_t      data;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  alu_input_t [3:0] req_input;
  logic [3:0]       req_ready;
  logic             alu_enable;
  alu_input_t       alu_input;
  data_t            alu_out;
  logic             resp_valid;
  logic             resp_ready;
  data_t            resp_data;
  logic [1:0]       resp_id;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t exp_q[$];
  int   resp_cyc[$];
  exp_t mon_e;

  alu_arbiter #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_input  (req_input),
    .req_ready  (req_ready),
    .alu_enable (alu_enable),
    .alu_input  (alu_input),
    .alu_out    (alu_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Behavioural ALU: registered result, synchronous reset, holds when disabled.
  function automatic data_t alu_f(input alu_input_t x);
    case (x.instruction)
      INSTR_ADD:  return x.rs1 + x.rs2;
      INSTR_SUB:  return x.rs1 - x.rs2;
      INSTR_XOR:  return x.rs1 ^ x.rs2;
      INSTR_ADDI: return x.rs1 + {{20{x.imm12[11]}}, x.imm12};
      INSTR_BEQ:  return (x.rs1 == x.rs2) ? 32'd1 : 32'd0;
      default:    return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) alu_out <= '0;
    else if (alu_enable) alu_out <= alu_f(alu_input);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: compare every completed response handshake against the scoreboard.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual id=%0d data=%0h required=none", resp_id, resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_id", 32'(resp_id), 32'(mon_e.id));
        chk("resp_data", resp_data, mon_e.data);
        resp_cyc.push_back(cycle);
      end
    end
  end

  task automatic set_req(input logic [1:0] idx, input instr_t op, input data_t a,
                         input data_t b, input logic [11:0] imm);
    req_input[idx] = '{rs1: a, rs2: b, imm12: imm, instruction: op};
    req_valid[idx] = 1'b1;
  endtask

  task automatic expect_resp(input logic [1:0] id, input data_t d);
    exp_q.push_back('{id: id, data: d});
  endtask

  // Run until requests are accepted and every expected response has drained.
  task automatic drain(input string name, input int budget);
    logic [3:0] acc;
    int n;
    n = 0;
    while ((req_valid != 4'd0 || busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] acc;
    int n;
    reset      = 1'b1;
    req_valid  = 4'b1111;
    req_input  = '0;
    resp_ready = 1'b1;

    // Reset state, with requests pending to show accept is masked.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_alu_enable", 32'(alu_enable), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_alu_input_zero", 32'(alu_input == '0), 32'd1);
    req_valid = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request: requester 2 ADD 5+7.
    @(posedge clk);
    #1;
    set_req(2'd2, INSTR_ADD, 32'd5, 32'd7, 12'd0);
    expect_resp(2'd2, 32'd12);
    @(negedge clk);
    chk("single_req_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = 4'd0;
    @(negedge clk);
    chk("single_exec_enable", 32'(alu_enable), 32'd1);
    chk("single_exec_busy", 32'(busy), 32'd1);
    chk("single_exec_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("single_resp_enable", 32'(alu_enable), 32'd0);
    chk("single_resp_valid", 32'(resp_valid), 32'd1);
    chk("single_resp_data", resp_data, 32'd12);
    chk("single_resp_id", 32'(resp_id), 32'd2);
    drain("single_drain", 20);

    // Full contention after reset: grants 0,1,2,3 then 0 again.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    resp_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      set_req(2'(i), INSTR_SUB, 32'd10, 32'(i), 12'd0);
    end
    expect_resp(2'd0, 32'd10);
    expect_resp(2'd1, 32'd9);
    expect_resp(2'd2, 32'd8);
    expect_resp(2'd3, 32'd7);
    drain("contention_drain", 60);
    chk("contention_resp_count", 32'(resp_cyc.size()), 32'd4);
    if (resp_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        chk("contention_spacing", 32'(resp_cyc[k] - resp_cyc[k-1]), 32'd3);
      end
    end
    set_req(2'd0, INSTR_SUB, 32'd10, 32'd0, 12'd0);
    set_req(2'd1, INSTR_SUB, 32'd10, 32'd1, 12'd0);
    expect_resp(2'd0, 32'd10);
    expect_resp(2'd1, 32'd9);
    drain("second_round_drain", 40);

    // Pointer wrap: grant 2 first, then 3 and 1 wrap past index 0.
    set_req(2'd2, INSTR_ADD, 32'd1, 32'd1, 12'd0);
    expect_resp(2'd2, 32'd2);
    drain("wrap_setup_drain", 20);
    set_req(2'd3, INSTR_ADD, 32'd30, 32'd3, 12'd0);
    set_req(2'd1, INSTR_ADD, 32'd10, 32'd1, 12'd0);
    expect_resp(2'd3, 32'd33);
    expect_resp(2'd1, 32'd11);
    drain("wrap_drain", 40);

    // Response backpressure: XOR held for 5 stalled RESP cycles, requester 1 waiting.
    resp_ready = 1'b0;
    set_req(2'd0, INSTR_XOR, 32'hF0, 32'hFF, 12'd0);
    set_req(2'd1, INSTR_ADD, 32'd2, 32'd2, 12'd0);
    expect_resp(2'd0, 32'h0F);
    expect_resp(2'd1, 32'd4);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (resp_valid) break;
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      n++;
    end
    chk("bp_resp_seen", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_data", resp_data, 32'h0F);
      chk("bp_alu_enable", 32'(alu_enable), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      if (k < 4) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_sixth_cycle_valid", 32'(resp_valid), 32'd1);
    drain("bp_drain", 30);

    // Reset while in EXEC discards the operation; priority returns to requester 0.
    set_req(2'd2, INSTR_ADD, 32'd1, 32'd2, 12'd0);
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = 4'd0;
    chk("midrst_exec_enable", 32'(alu_enable), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_alu_enable", 32'(alu_enable), 32'd0);
    chk("midrst_alu_input_zero", 32'(alu_input == '0), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    set_req(2'd0, INSTR_ADD, 32'd4, 32'd4, 12'd0);
    set_req(2'd3, INSTR_ADD, 32'd6, 32'd6, 12'd0);
    expect_resp(2'd0, 32'd8);
    expect_resp(2'd3, 32'd12);
    drain("midrst_drain", 40);

    // Immediate, branch and invalid-instruction passthrough.
    set_req(2'd1, INSTR_ADDI, 32'd1, 32'd99, 12'hFFF);
    set_req(2'd2, INSTR_BEQ, 32'd3, 32'd3, 12'd0);
    set_req(2'd3, 4'hF, 32'd5, 32'd5, 12'd0);
    expect_resp(2'd1, 32'd0);
    expect_resp(2'd2, 32'd1);
    expect_resp(2'd3, 32'd0);
    drain("passthru_drain", 40);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance among `NUM_REQ` requesters, such as warp lanes or per-thread execution slots, using round-robin arbitration.
- It sequences each operation through the ALU's registered, one-cycle datapath.
- It returns the result to the winning requester with a valid/ready response handshake.
- It sits between the thread execution logic and a single ALU, so area is traded for throughput.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `ID_WIDTH`, default `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, `NUM_REQ`: requester i has an operation pending.
- `req_input`, input, `NUM_REQ` × `alu_input_t`: per-requester operation payload (`rs1`, `rs2`, `imm12`, `instruction`).
- `req_ready`, output, `NUM_REQ`: one-hot accept; the request transfers when `req_valid[i] & req_ready[i]`.
- `alu_enable`, output, 1: drives the ALU `enable` input.
- `alu_input`, output, `alu_input_t`: drives the ALU operand/instruction input.
- `alu_out`, input, `data_t`: registered result from the ALU.
- `resp_valid`, output, 1: a result is available.
- `resp_ready`, input, 1: the consumer accepts the result.
- `resp_data`, output, `data_t`: the result.
- `resp_id`, output, `ID_WIDTH`: index of the requester that owns `resp_data`.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
The block is a three-state FSM: IDLE, EXEC, RESP.

**IDLE**
- Grant selection:
  - If any `req_valid` is high, grant `g` is the first index with `req_valid` set.
  - Search order is `rr_ptr+1`, `rr_ptr+2`, …, wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is asserted combinationally in the same cycle.
- On the edge:
  - `op_reg <= req_input[g]`, `id_reg <= g`, `rr_ptr <= g`.
  - Next state is EXEC.
- If no `req_valid` is high, stay in IDLE.
- `req_ready` is all-zero outside IDLE and all-zero when no request is pending.

**EXEC**
- `alu_enable = 1` and `alu_input = op_reg` for exactly one cycle.
- Next state is RESP unconditionally.

**RESP**
- `resp_valid = 1`, `resp_data = alu_out`, `resp_id = id_reg`.
- `alu_enable = 0`, so the ALU holds `alu_out` stable.
- If `resp_ready` is high, next state is IDLE; otherwise stay in RESP with all response outputs held.

**General rules**
- `alu_input` is driven from `op_reg` in every state; `alu_enable` is high only in EXEC.
- The payload is not inspected. An invalid instruction is passed through, and the ALU's result (0) is returned.
- `resp_id` equals `id_reg` in all states; it is meaningful only while `resp_valid` is high.
- Requesters must hold `req_valid` and `req_input` stable until accepted, and `req_valid` must not depend on `req_ready`.

**Reset** (asynchronous, takes effect immediately, including mid-operation)
- State becomes IDLE and `rr_ptr` becomes `NUM_REQ-1`, so requester 0 has first priority.
- `op_reg`, `id_reg`, `alu_input` are 0; `alu_enable`, `resp_valid`, `req_ready`, `busy` are 0; `resp_id` is 0.
- Any in-flight operation is discarded without a response.
- The ALU shares `reset`; its synchronous reset clears `alu_out` while `alu_enable` is held 0.

## Timing
- Accept edge T (IDLE, `req_valid[g] & req_ready[g]`); EXEC occupies cycle T+1; `resp_valid` rises in cycle T+2.
- Accept-to-response latency is 2 cycles.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP), so peak throughput is 1 operation per 3 cycles.
- Each cycle of `resp_ready` low adds one cycle; there is no bound on response stall.
- The next accept can occur no earlier than the cycle after the response handshake.
- Starvation bound: a requester holding `req_valid` is granted within `NUM_REQ` arbitrations.
- Simultaneous requests: exactly one is granted per IDLE cycle; the rest wait with `req_ready = 0`.

## Test plan
- **Single request:** requester 2 issues ADD with `rs1=5`, `rs2=7` at idle.
  - `req_ready = 0b0100` in the same cycle.
  - `alu_enable` is high for one cycle.
  - At T+2: `resp_valid = 1`, `resp_data = 12`, `resp_id = 2`.
- **Full contention after reset:** all four requesters valid, each with SUB `rs1=10`, `rs2=i`.
  - Grant order is 0, 1, 2, 3, then 0 again.
  - Results in order: 10, 9, 8, 7.
  - Responses arrive every 3 cycles.
- **Pointer wrap:** requesters 3 and 1 valid, with `rr_ptr = 2` after a grant to 2.
  - Grants go to 3, then 1, wrapping past index 0.
  - `resp_id` sequence is 3, 1.
- **Response backpressure:** XOR `rs1=0xF0`, `rs2=0xFF` with `resp_ready` low for 5 cycles.
  - `resp_valid` stays high with `resp_data = 0x0F`; `alu_enable` stays 0; `req_ready` stays 0.
  - The handshake completes on the 6th RESP cycle.
- **Reset mid-operation:** assert `reset` asynchronously while in EXEC.
  - Outputs clear immediately: `busy = 0`, `resp_valid = 0`, `alu_enable = 0`.
  - No response is produced for the discarded operation.
  - After release, requester 0 has priority again.
- **Immediate/branch passthrough:** ADDI `rs1=1` with `imm12=0xFFF` returns 0; BEQ `rs1=rs2=3` returns 1; both are routed to the correct `resp_id`.
